// File: rtl/dom_mask_rng.sv
// rtl/dom_mask_rng.sv - LFSR-based fresh-mask generator for a DOM masked inverter
module dom_mask_rng #(
  parameter int SHARES          = 2,
  parameter int BLIND_NRND      = 1,
  parameter int WARMUP_CYCLES   = 16,
  parameter int RESEED_INTERVAL = 1024
) (
  input  logic                             ClkxCI,
  input  logic                             RstxRI,
  input  logic [63:0]                      SeedxDI,
  input  logic                             SeedValidxSI,
  output logic                             SeedReadyxSO,
  input  logic                             EnxSI,
  output logic                             RndValidxSO,
  output logic [SHARES*(SHARES-1)-1:0]     _Zmul1xDO,
  output logic [SHARES*(SHARES-1)-1:0]     _Zmul2xDO,
  output logic [SHARES*(SHARES-1)-1:0]     _Zmul3xDO,
  output logic [2*BLIND_NRND-1:0]          _Bmul1xDO,
  output logic [2*BLIND_NRND-1:0]          _Bmul2xDO,
  output logic [2*BLIND_NRND-1:0]          _Bmul3xDO,
  output logic                             ReseedReqxSO,
  output logic                             ZeroSeedxSO
);

  localparam int ZW = SHARES * (SHARES - 1);
  localparam int BW = 2 * BLIND_NRND;
  localparam int W  = 3 * ZW + 3 * BW;

  if (W > 64) begin : g_width_check
    $error("dom_mask_rng: randomness width exceeds the 64-bit LFSR");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_RUN,
    ST_EXHAUSTED
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [63:0] r_s, w_s_nxt;
  logic [7:0]  r_warm, w_warm_nxt;
  logic [15:0] r_used, w_used_nxt;
  logic        r_zero, w_zero_nxt;
  logic        w_accept;
  logic [63:0] w_s_adv;
  logic [15:0] w_used_inc;

  // W taps of the x^64+x^63+x^61+x^60+1 recurrence unrolled into one cycle.
  function automatic logic [63:0] lfsr_advance(input logic [63:0] s);
    logic [63:0] v;
    v = s;
    for (int i = 0; i < W; i++) begin
      v = {v[62:0], v[63] ^ v[62] ^ v[60] ^ v[59]};
    end
    return v;
  endfunction

  assign w_s_adv    = lfsr_advance(r_s);
  assign w_used_inc = r_used + 16'd1;

  always_ff @(posedge ClkxCI) begin
    if (RstxRI) begin
      r_state <= ST_IDLE;
      r_s     <= 64'd0;
      r_warm  <= 8'd0;
      r_used  <= 16'd0;
      r_zero  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_s     <= w_s_nxt;
      r_warm  <= w_warm_nxt;
      r_used  <= w_used_nxt;
      r_zero  <= w_zero_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_s_nxt      = r_s;
    w_warm_nxt   = r_warm;
    w_used_nxt   = r_used;
    w_zero_nxt   = 1'b0;
    SeedReadyxSO = (r_state != ST_WARMUP);
    RndValidxSO  = (r_state == ST_RUN);
    ReseedReqxSO = (r_state == ST_EXHAUSTED);
    w_accept     = SeedValidxSI && SeedReadyxSO;

    case (r_state)
      ST_WARMUP: begin
        // One extra non-advancing cycle after the last advance lets RUN start
        // WARMUP_CYCLES+1 cycles after the load.
        if (r_warm < 8'(WARMUP_CYCLES)) begin
          w_s_nxt    = w_s_adv;
          w_warm_nxt = r_warm + 8'd1;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!w_accept && EnxSI) begin
          w_s_nxt    = w_s_adv;
          w_used_nxt = w_used_inc;
          if (w_used_inc == 16'(RESEED_INTERVAL)) begin
            w_state_nxt = ST_EXHAUSTED;
          end
        end
      end
      default: ;
    endcase

    // A seed load overrides any consumption in the same cycle.
    if (w_accept) begin
      w_s_nxt     = (SeedxDI == 64'd0) ? 64'd1 : SeedxDI;
      w_zero_nxt  = (SeedxDI == 64'd0);
      w_used_nxt  = 16'd0;
      w_warm_nxt  = 8'd0;
      w_state_nxt = ST_WARMUP;
    end
  end

  assign ZeroSeedxSO = r_zero;
  assign _Zmul1xDO   = r_s[ZW-1:0];
  assign _Zmul2xDO   = r_s[2*ZW-1:ZW];
  assign _Zmul3xDO   = r_s[3*ZW-1:2*ZW];
  assign _Bmul1xDO   = r_s[3*ZW+BW-1:3*ZW];
  assign _Bmul2xDO   = r_s[3*ZW+2*BW-1:3*ZW+BW];
  assign _Bmul3xDO   = r_s[3*ZW+3*BW-1:3*ZW+2*BW];

endmodule

// File: tb/tb_dom_mask_rng.sv
// tb/tb_dom_mask_rng.sv - randomized bench for dom_mask_rng against a cycle reference model
module tb_dom_mask_rng;

  localparam int SHARES   = 2;
  localparam int BN       = 1;
  localparam int WARM     = 16;
  localparam int INTERVAL = 4;
  localparam int ZW       = SHARES * (SHARES - 1);
  localparam int BW       = 2 * BN;
  localparam int W        = 3 * ZW + 3 * BW;

  logic          clk = 1'b0;
  logic          rst;
  logic [63:0]   seed;
  logic          seed_valid;
  logic          seed_ready;
  logic          en;
  logic          rnd_valid;
  logic [ZW-1:0] z1, z2, z3;
  logic [BW-1:0] b1, b2, b3;
  logic          reseed_req;
  logic          zero_seed;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  dom_mask_rng #(
    .SHARES(SHARES), .BLIND_NRND(BN), .WARMUP_CYCLES(WARM), .RESEED_INTERVAL(INTERVAL)
  ) dut (
    .ClkxCI(clk), .RstxRI(rst), .SeedxDI(seed), .SeedValidxSI(seed_valid),
    .SeedReadyxSO(seed_ready), .EnxSI(en), .RndValidxSO(rnd_valid),
    ._Zmul1xDO(z1), ._Zmul2xDO(z2), ._Zmul3xDO(z3),
    ._Bmul1xDO(b1), ._Bmul2xDO(b2), ._Bmul3xDO(b3),
    .ReseedReqxSO(reseed_req), .ZeroSeedxSO(zero_seed)
  );

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: the LFSR as a plain shift register recurrence, n single steps.
  function automatic logic [63:0] ref_steps(input logic [63:0] s, input int n);
    logic [63:0] v;
    logic [63:0] fb;
    v = s;
    for (int i = 0; i < n; i++) begin
      fb = ((v >> 63) ^ (v >> 62) ^ (v >> 60) ^ (v >> 59)) & 64'd1;
      v  = (v << 1) | fb;
    end
    return v;
  endfunction

  // Model: m_warm counts warmup advances done, -1 when no warmup is in progress.
  logic [63:0] m_s;
  int          m_warm;
  int          m_used;
  bit          m_run, m_exh, m_zero;

  task automatic model_edge(input logic r, input logic sv, input logic [63:0] sd, input logic e);
    if (r) begin
      m_s = 64'd0; m_warm = -1; m_used = 0; m_run = 0; m_exh = 0; m_zero = 0;
    end else begin
      m_zero = 0;
      if (sv && m_warm < 0) begin
        m_s    = (sd == 64'd0) ? 64'd1 : sd;
        m_zero = (sd == 64'd0);
        m_used = 0; m_warm = 0; m_run = 0; m_exh = 0;
      end else if (m_warm >= 0) begin
        if (m_warm < WARM) begin
          m_s = ref_steps(m_s, W);
          m_warm++;
        end else begin
          m_warm = -1;
          m_run  = 1;
        end
      end else if (m_run && e) begin
        m_s = ref_steps(m_s, W);
        m_used++;
        if (m_used == INTERVAL) begin
          m_run = 0;
          m_exh = 1;
        end
      end
    end
  endtask

  task automatic cyc(input logic r, input logic sv, input logic [63:0] sd, input logic e);
    logic [W-1:0] rnd_obs;
    logic [63:0]  rnd_exp;
    rst = r; seed_valid = sv; seed = sd; en = e;
    #1;
    if (chk_on) begin
      rnd_obs = {b3, b2, b1, z3, z2, z1};
      rnd_exp = m_s & ((64'd1 << W) - 64'd1);
      chk_eq("seed_ready", 64'(seed_ready), 64'(m_warm < 0));
      chk_eq("rnd_valid", 64'(rnd_valid), 64'(m_run));
      chk_eq("reseed_req", 64'(reseed_req), 64'(m_exh));
      chk_eq("zero_seed", 64'(zero_seed), 64'(m_zero));
      chk_eq("rnd_word", 64'(rnd_obs), rnd_exp);
    end
    @(posedge clk);
    model_edge(r, sv, sd, e);
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n, input logic e);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 64'd0, e);
  endtask

  initial begin
    int          lat;
    logic [63:0] rs;
    rst = 1'b1; seed_valid = 1'b0; seed = 64'd0; en = 1'b0;
    @(negedge clk);
    cyc(1'b1, 1'b0, 64'd0, 1'b0);
    chk_on = 1'b1;
    cyc(1'b1, 1'b0, 64'd0, 1'b0);
    idle_cycles(2, 1'b1);

    // Fixed seed: valid latency and warmed-up word.
    cyc(1'b0, 1'b1, 64'h0123456789ABCDEF, 1'b0);
    lat = 0;
    while (!rnd_valid && lat < 40) begin
      cyc(1'b0, 1'b0, 64'd0, 1'b0);
      lat++;
    end
    chk_eq("warmup_latency", 64'(lat), 64'd17);
    chk_eq("warmup_word", 64'({b3, b2, b1, z3, z2, z1}),
           ref_steps(64'h0123456789ABCDEF, WARM * W) & 64'hFFF);

    // Held outputs, then consume to exhaustion and beyond.
    idle_cycles(10, 1'b0);
    idle_cycles(8, 1'b1);
    cyc(1'b0, 1'b1, 64'hDEADBEEFCAFEF00D, 1'b0);
    idle_cycles(WARM + 2, 1'b1);

    // Zero seed behaves as seed 1.
    cyc(1'b0, 1'b1, 64'd0, 1'b0);
    idle_cycles(WARM + 1, 1'b0);
    idle_cycles(INTERVAL + 1, 1'b1);

    // Seed offered with consume in RUN: the seed wins.
    cyc(1'b0, 1'b1, 64'h1, 1'b0);
    idle_cycles(WARM + 1, 1'b0);
    cyc(1'b0, 1'b0, 64'd0, 1'b1);
    cyc(1'b0, 1'b1, 64'h5555AAAA5555AAAA, 1'b1);
    cyc(1'b0, 1'b1, 64'h1234, 1'b1);
    idle_cycles(WARM + 1, 1'b0);
    idle_cycles(10, 1'b0);
    idle_cycles(INTERVAL + 2, 1'b1);

    // Reset during warmup, then a full warmup from a fresh seed.
    cyc(1'b0, 1'b1, 64'hFEEDFACE00112233, 1'b0);
    idle_cycles(5, 1'b0);
    cyc(1'b1, 1'b0, 64'd0, 1'b1);
    chk_eq("rst_outputs", 64'({rnd_valid, reseed_req, zero_seed, b3, b2, b1, z3, z2, z1}), 64'd0);
    cyc(1'b0, 1'b1, 64'h0F0F0F0F0F0F0F0F, 1'b0);
    idle_cycles(WARM + 3, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      rs = ($urandom_range(0, 9) == 0) ? 64'd0 : {$urandom, $urandom};
      cyc(($urandom_range(0, 149) == 0), ($urandom_range(0, 11) == 0), rs,
          1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
